// File: rtl/ifetch.sv
// Instruction fetch front end: issues word-aligned reads, tracks in-flight requests,
// drops responses made stale by a flush and buffers returned words for decode.
module ifetch #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    input  logic        pc_valid_i,
    output logic        pc_ready_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        flush_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0] pend_cnt_q, pend_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [AW-1:0] aq_wr_q, aq_rd_q, ff_wr_q, ff_rd_q;
    logic [31:0]   aq_mem [DEPTH];
    logic [63:0]   ff_mem [DEPTH];

    logic [CW+1:0] occ;
    logic          credit, accept, rv_drop, rv_take, push, pop;

    // Every slot is reserved from issue until the word leaves the FIFO, so
    // neither queue can ever be written past its depth.
    assign occ    = {2'b00, pend_cnt_q} + {2'b00, drop_cnt_q} + {2'b00, fifo_cnt_q};
    assign credit = occ < (CW+2)'(DEPTH);

    assign mem_req_o     = rst_n && pc_valid_i && credit && !flush_i;
    assign mem_addr_o    = {pc_i[31:2], 2'b00};
    assign pc_ready_o    = mem_req_o && mem_gnt_i;
    assign accept        = pc_ready_o;

    assign rv_drop       = mem_rvalid_i && (drop_cnt_q != '0);
    assign rv_take       = mem_rvalid_i && (drop_cnt_q == '0) && (pend_cnt_q != '0);
    assign push          = rv_take && !flush_i;

    assign instr_valid_o = rst_n && (fifo_cnt_q != '0) && !flush_i;
    assign pop           = instr_valid_o && instr_ready_i;
    assign instr_o       = ff_mem[ff_rd_q][31:0];
    assign instr_pc_o    = ff_mem[ff_rd_q][63:32];

    always_comb begin
        pend_cnt_d = pend_cnt_q;
        drop_cnt_d = drop_cnt_q;
        fifo_cnt_d = fifo_cnt_q;
        if (flush_i) begin
            // A response landing in the flush cycle retires one of the old slots.
            drop_cnt_d = drop_cnt_q + pend_cnt_q - CW'(rv_drop || rv_take);
            pend_cnt_d = '0;
            fifo_cnt_d = '0;
        end else begin
            pend_cnt_d = pend_cnt_q + CW'(accept) - CW'(rv_take);
            drop_cnt_d = drop_cnt_q - CW'(rv_drop);
            fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_cnt_q <= '0;
            drop_cnt_q <= '0;
            fifo_cnt_q <= '0;
            aq_wr_q    <= '0;
            aq_rd_q    <= '0;
            ff_wr_q    <= '0;
            ff_rd_q    <= '0;
        end else begin
            pend_cnt_q <= pend_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            if (flush_i) begin
                aq_wr_q <= '0;
                aq_rd_q <= '0;
                ff_wr_q <= '0;
                ff_rd_q <= '0;
            end else begin
                aq_wr_q <= aq_wr_q + AW'(accept);
                aq_rd_q <= aq_rd_q + AW'(rv_take);
                ff_wr_q <= ff_wr_q + AW'(push);
                ff_rd_q <= ff_rd_q + AW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) aq_mem[aq_wr_q] <= pc_i;
        if (push)   ff_mem[ff_wr_q] <= {aq_mem[aq_rd_q], mem_rdata_i};
    end

endmodule
